// File: rtl/button_pulse_gen.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM and optional hold-to-auto-repeat.
// Emits one registered strobe per accepted press (and per repeat interval while held).
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_pulse,
  output logic btn_level,
  output logic btn_held
);

  localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 32'sd1);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic             sync1_r;
  logic             sync2_r;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce / hold / repeat FSM; outputs are decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
      btn_held  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          count_r   <= CNT_ZERO;
          btn_pulse <= 1'b0;
          btn_level <= 1'b0;
          btn_held  <= 1'b0;
          if (sync2_r) begin
            state_r <= ST_DEB_PRESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_DEB_PRESS: begin
          btn_held <= 1'b0;
          if (!sync2_r) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            btn_pulse <= 1'b0;
            btn_level <= 1'b0;
          end else if (count_r == DEB_LAST) begin
            state_r   <= ST_PRESSED;
            count_r   <= CNT_ZERO;
            btn_pulse <= 1'b1;
            btn_level <= 1'b1;
          end else begin
            state_r   <= ST_DEB_PRESS;
            count_r   <= count_r + CNT_ONE;
            btn_pulse <= 1'b0;
            btn_level <= 1'b0;
          end
        end

        // Release takes priority over a hold expiry on the same cycle.
        ST_PRESSED: begin
          btn_level <= 1'b1;
          if (!sync2_r) begin
            state_r   <= ST_DEB_RELEASE;
            count_r   <= CNT_ZERO;
            btn_pulse <= 1'b0;
            btn_held  <= 1'b0;
          end else if ((REPEAT_EN == 1'b1) && (count_r == HOLD_LAST)) begin
            state_r   <= ST_REPEAT;
            count_r   <= CNT_ZERO;
            btn_pulse <= 1'b1;
            btn_held  <= 1'b1;
          end else begin
            state_r   <= ST_PRESSED;
            count_r   <= (count_r == CNT_SAT) ? count_r : (count_r + CNT_ONE);
            btn_pulse <= 1'b0;
            btn_held  <= 1'b0;
          end
        end

        ST_REPEAT: begin
          btn_level <= 1'b1;
          if (!sync2_r) begin
            state_r   <= ST_DEB_RELEASE;
            count_r   <= CNT_ZERO;
            btn_pulse <= 1'b0;
            btn_held  <= 1'b0;
          end else if (count_r == REP_LAST) begin
            state_r   <= ST_REPEAT;
            count_r   <= CNT_ZERO;
            btn_pulse <= 1'b1;
            btn_held  <= 1'b1;
          end else begin
            state_r   <= ST_REPEAT;
            count_r   <= count_r + CNT_ONE;
            btn_pulse <= 1'b0;
            btn_held  <= 1'b1;
          end
        end

        // A bounce back to 1 returns to PRESSED and restarts the hold timer.
        ST_DEB_RELEASE: begin
          btn_pulse <= 1'b0;
          btn_held  <= 1'b0;
          if (sync2_r) begin
            state_r   <= ST_PRESSED;
            count_r   <= CNT_ZERO;
            btn_level <= 1'b1;
          end else if (count_r == DEB_LAST) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            btn_level <= 1'b0;
          end else begin
            state_r   <= ST_DEB_RELEASE;
            count_r   <= count_r + CNT_ONE;
            btn_level <= 1'b1;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          count_r   <= CNT_ZERO;
          btn_pulse <= 1'b0;
          btn_level <= 1'b0;
          btn_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench for button_pulse_gen: one repeat-enabled and one repeat-disabled instance
// share the same button; a run-length reference model predicts every cycle's outputs.
module tb_button_pulse_gen;

  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic pulse_r, level_r, held_r;
  logic pulse_n, level_n, held_n;
  logic [1:0] sel;

  always #5 clk = ~clk;

  button_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut_rep (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_pulse(pulse_r), .btn_level(level_r), .btn_held(held_r)
  );

  button_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut_norep (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_pulse(pulse_n), .btn_level(level_n), .btn_held(held_n)
  );

  // Mode-select FSM stand-in: advances one step per strobe, 00 -> 01 -> 10 -> 00.
  always_ff @(posedge clk) begin
    if (reset) sel <= 2'd0;
    else if (pulse_n) sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    else sel <= sel;
  end

  typedef struct packed {
    logic pulse;
    logic level;
    logic held;
  } exp_t;

  exp_t       q_rep[$];
  exp_t       q_norep[$];
  logic [1:0] q_sel[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state, index 0 = repeat enabled, 1 = repeat disabled.
  int ones[2];
  int zeros[2];
  int pstart[2];
  bit lvl[2];
  bit pipe1, pipe2;
  int sel_m;
  bit prev_pulse_n;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit b);
    exp_t e[2];
    bit   x;
    int   age;
    if (rst) begin
      pipe1 = 1'b0;
      pipe2 = 1'b0;
      sel_m = 0;
      for (int k = 0; k < 2; k++) begin
        ones[k] = 0; zeros[k] = 0; pstart[k] = 0; lvl[k] = 1'b0;
        e[k] = '0;
      end
    end else begin
      x     = pipe2;
      pipe2 = pipe1;
      pipe1 = b;
      if (prev_pulse_n) sel_m = (sel_m + 1) % 3;
      for (int k = 0; k < 2; k++) begin
        e[k] = '0;
        if (x) begin ones[k]++; zeros[k] = 0; end
        else begin zeros[k]++; ones[k] = 0; end
        if (!lvl[k]) begin
          // press accepted after D+1 consecutive synchronised highs
          if (x && ones[k] == D + 1) begin
            lvl[k] = 1'b1;
            e[k].pulse = 1'b1;
            pstart[k] = cyc;
          end
        end else if (x) begin
          if (ones[k] == 1) pstart[k] = cyc;
          age = cyc - pstart[k];
          if (k == 0 && age >= H) begin
            e[k].held = 1'b1;
            if ((age - H) % R == 0) e[k].pulse = 1'b1;
          end
        end else if (zeros[k] == D + 1) begin
          lvl[k] = 1'b0;
        end
        e[k].level = lvl[k];
      end
    end
    prev_pulse_n = e[1].pulse;
    q_rep.push_back(e[0]);
    q_norep.push_back(e[1]);
    q_sel.push_back(2'(sel_m));
  endtask

  task automatic step(input bit r, input bit b);
    @(negedge clk);
    reset  = r;
    btn_in = b;
    cyc++;
    model_edge(r, b);
  endtask

  // Monitor: pops one expectation per clock edge and compares it with the DUT outputs.
  initial begin
    exp_t       e;
    logic [1:0] s;
    bit         last_pr, last_pn;
    last_pr = 1'b0;
    last_pn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (q_rep.size() > 0) begin
        e = q_rep.pop_front();
        chk("rep_pulse", 32'(pulse_r), 32'(e.pulse));
        chk("rep_level", 32'(level_r), 32'(e.level));
        chk("rep_held",  32'(held_r),  32'(e.held));
        e = q_norep.pop_front();
        chk("norep_pulse", 32'(pulse_n), 32'(e.pulse));
        chk("norep_level", 32'(level_n), 32'(e.level));
        chk("norep_held",  32'(held_n),  32'(e.held));
        s = q_sel.pop_front();
        chk("mode_sel", 32'(sel), 32'(s));
        if (pulse_r) chk("rep_pulse_back_to_back", 32'(last_pr), 32'd0);
        if (pulse_n) chk("norep_pulse_back_to_back", 32'(last_pn), 32'd0);
        last_pr = pulse_r;
        last_pn = pulse_n;
      end
    end
  end

  initial begin
    bit    bounce_p[5];
    bit    bounce_r[3];
    bit    found;
    bit    v;
    int    len;
    bounce_p = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bounce_r = '{1'b0, 1'b1, 1'b0};
    reset = 1'b1;
    btn_in = 1'b0;
    prev_pulse_n = 1'b0;

    repeat (3) step(1'b1, 1'b0);

    // clean press then release
    repeat (40) step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // bouncy press and bouncy release
    foreach (bounce_p[i]) step(1'b0, bounce_p[i]);
    repeat (30) step(1'b0, 1'b1);
    foreach (bounce_r[i]) step(1'b0, bounce_r[i]);
    repeat (20) step(1'b0, 1'b0);

    // release lands on a repeat expiry
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (lvl[0] && (cyc + 3 - pstart[0]) == H + 2 * R) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b1);
    end
    chk("collision_setup", 32'(found), 32'd1);
    repeat (20) step(1'b0, 1'b0);

    // reset during debounce, button still held
    repeat (3) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    repeat (15) step(1'b0, 1'b0);

    // reset during auto-repeat, button still held
    repeat (25) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    repeat (15) step(1'b0, 1'b0);

    // three presses walk the mode selector round once
    repeat (3) begin
      repeat (12) step(1'b0, 1'b1);
      repeat (12) step(1'b0, 1'b0);
    end

    // random segments with occasional reset
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      if ($urandom_range(0, 20) == 0) step(1'b1, v);
      repeat (len) step(1'b0, v);
    end
    repeat (20) step(1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q_rep.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_pulse_gen.md
Name: button_pulse_gen

Overview:
- Conditions one raw push-button into a clean one-cycle strobe for mode-select FSMs such as the scale/display-mode selector.
- Those FSMs advance one state per cycle that their button input is high, so they need exactly one pulse per physical press.
- Pipeline: 2-flop synchroniser, debounce FSM with counter, optional hold-to-auto-repeat.
- Sits between the board button pins and the mode-select FSM's button input; one instance per button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles input must be stable to accept press or release (10 ms at 100 MHz); must be >= 2.
- REPEAT_EN, 0, 1 enables auto-repeat pulses while held.
- HOLD_CYCLES, 50000000, cycles held in PRESSED before the first repeat pulse; must be >= 2.
- REPEAT_CYCLES, 25000000, interval between repeat pulses; must be >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous, bouncing button, active-high.
- btn_pulse  output  1  registered; high exactly one cycle per accepted press or repeat.
- btn_level  output  1  registered debounced button level.
- btn_held  output  1  registered; high while in auto-repeat.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: sync flops=0, state=IDLE, counter=0, btn_pulse=0, btn_level=0, btn_held=0.
- Synchroniser: btn_in -> s1 -> s2. The FSM uses s2 only.
- Counter width: $clog2 of max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES). Counter is cleared on every state change.
- IDLE: s2=1 -> DEB_PRESS.
- DEB_PRESS:
  - s2=0 -> IDLE, no pulse.
  - s2=1 and count==DEBOUNCE_CYCLES-1 -> PRESSED, with btn_pulse=1 for that next cycle.
  - Otherwise count+1.
- PRESSED:
  - s2=0 -> DEB_RELEASE.
  - REPEAT_EN=1 and count==HOLD_CYCLES-1 -> REPEAT, with btn_pulse=1.
  - Otherwise count+1. With REPEAT_EN=0 the counter saturates and does not wrap.
- REPEAT:
  - s2=0 -> DEB_RELEASE.
  - count==REPEAT_CYCLES-1: btn_pulse=1, count=0, stay in REPEAT.
  - Otherwise count+1.
- DEB_RELEASE:
  - s2=1 -> PRESSED, no pulse; the hold timer restarts, including when entered from REPEAT.
  - s2=0 and count==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise count+1.
- Output decode (registered from next state):
  - btn_level=1 in PRESSED, REPEAT and DEB_RELEASE.
  - btn_held=1 in REPEAT only.
  - btn_pulse=1 only on the listed transitions; never high two consecutive cycles.
- Latency: btn_in first sampled high at edge t0 and stable thereafter -> btn_pulse high during the cycle following edge t0+DEBOUNCE_CYCLES+2.
- Glitches: any 0 on s2 during DEB_PRESS aborts the press. Bounce on release never produces a pulse.
- Simultaneous events:
  - In PRESSED/REPEAT, s2=0 on the same cycle the timer expires -> release wins; go to DEB_RELEASE, no pulse.
- Reset mid-operation: immediate return to reset values; a pending pulse is dropped.
- Button held through reset deassertion: treated as a new press; one pulse after DEBOUNCE_CYCLES+2 cycles.
- REPEAT_EN=0: HOLD_CYCLES and REPEAT_CYCLES are ignored; REPEAT is unreachable.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4, REPEAT_EN=0: btn_in 0->1 sampled at edge 10, held 40 cycles -> btn_pulse high only in the cycle after edge 16; btn_level rises with it; a single pulse overall.
- Bounce, DEBOUNCE_CYCLES=4: btn_in toggles 1,0,1,1,0 then holds 1 -> no pulse until 4 stable s2 cycles, then exactly one pulse. Release bounce 0,1,0 then 0 -> btn_level falls 4 stable cycles later, no pulse.
- Auto-repeat, DEBOUNCE=4, HOLD=8, REPEAT=3, REPEAT_EN=1, held 30 cycles after acceptance:
  - pulses at acceptance, at +8 cycles, then every 3 cycles;
  - btn_held=1 from the first repeat pulse;
  - btn_held clears on the first release cycle.
- Release collides with repeat expiry: s2 falls on the cycle count==REPEAT_CYCLES-1 -> no pulse; state DEB_RELEASE; btn_held=0 next cycle.
- Reset mid-DEB_PRESS and mid-REPEAT:
  - all outputs 0 the cycle after reset;
  - with the button still held after deassert, exactly one pulse DEBOUNCE_CYCLES+2 cycles later.
- System check: drive the mode-select FSM with btn_pulse and press 3 times -> selector sequence 00->01->10->00, with exactly one step per press.
